// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates instruction-fetch and data ports onto one shared memory port
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   if_req/if_addr                 fetch request in; if_rdata/if_valid fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request in; dm_rdata/dm_done load data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  shared memory request out; mem_ack/mem_rdata completion in
//   stall_if, stall_mem            pipeline hold signals
//   err                            timeout flag, pulses together with the done pulse
module mem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
   state_t     state;
   logic [2:0] streak;
   logic [7:0] wait_cnt;
   logic       grant_i;
   logic       give_up;
   // data wins ties unless the fetch port has already been passed over MAX_STREAK times
   assign grant_i   = if_req & (~dm_req | (streak == 3'(MAX_STREAK)));
   assign give_up   = wait_cnt == 8'(TIMEOUT - 1);
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_done;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_done   <= 1'b0;
         err       <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_done  <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: if (if_req | dm_req) begin
               state     <= grant_i ? BUSY_I : BUSY_D;
               mem_req   <= 1'b1;
               mem_we    <= grant_i ? 1'b0 : dm_we;
               mem_addr  <= grant_i ? if_addr : dm_addr;
               mem_wdata <= grant_i ? '0 : dm_wdata;
               wait_cnt  <= '0;
               streak    <= (grant_i | ~if_req) ? 3'd0 :
                            (streak == 3'(MAX_STREAK)) ? streak : streak + 3'd1;
            end
            BUSY_I, BUSY_D: if (mem_ack | give_up) begin
               state   <= RESP;
               mem_req <= 1'b0;
               err     <= ~mem_ack;
               if (state == BUSY_I) begin
                  if_rdata <= mem_ack ? mem_rdata : '0;
                  if_valid <= 1'b1;
               end else begin
                  // stores and timed-out loads both return zero
                  dm_rdata <= (mem_ack & ~mem_we) ? mem_rdata : '0;
                  dm_done  <= 1'b1;
               end
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
            RESP: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int AW = 16, DW = 32, TO = 255, MS = 4;
   logic          clk = 1'b0, rst = 1'b1;
   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          if_valid, dm_done, mem_req, mem_we, stall_if, stall_mem, err;
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .MAX_STREAK(MS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   // transaction model: phase 0 free, 1 memory outstanding, 2 responding; who 0 fetch, 1 data
   int            ph = 0, who = 0, wcnt = 0, streak = 0, n_req = 0, n_done = 0;
   logic [AW-1:0] e_addr = '0;
   logic          e_we = 1'b0, e_err = 1'b0, pm = 1'b0;
   logic [DW-1:0] e_wdata = '0, e_if = '0, e_dm = '0;
   logic          dq[$];
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cycle();
      logic r, ir, dr, dw, ak;
      logic [AW-1:0] ia, da;
      logic [DW-1:0] wd, rd, v;
      r = rst; ir = if_req; dr = dm_req; dw = dm_we; ak = mem_ack;
      ia = if_addr; da = dm_addr; wd = dm_wdata; rd = mem_rdata;
      @(posedge clk);
      #1;
      if (r) begin
         ph = 0; streak = 0; e_if = '0; e_dm = '0; e_err = 1'b0;
      end else if (ph == 0) begin
         if (ir || dr) begin
            who    = (dr && !(ir && streak == MS)) ? 1 : 0;
            streak = (who == 0 || !ir) ? 0 : (streak < MS ? streak + 1 : MS);
            e_addr = who == 1 ? da : ia;
            e_we   = who == 1 ? dw : 1'b0;
            e_wdata = wd;
            ph = 1; wcnt = 0;
         end
      end else if (ph == 1) begin
         if (ak || wcnt == TO - 1) begin
            ph = 2; e_err = !ak;
            v = (ak && !e_we) ? rd : '0;
            if (who == 1) e_dm = v; else e_if = v;
         end else wcnt++;
      end else ph = 0;
      chk("mem_req", mem_req, ph == 1);
      chk("if_valid", if_valid, ph == 2 && who == 0);
      chk("dm_done", dm_done, ph == 2 && who == 1);
      chk("err", err, ph == 2 && e_err);
      chk("if_rdata", if_rdata, e_if);
      chk("dm_rdata", dm_rdata, e_dm);
      chk("stall_if", stall_if, if_req && !(ph == 2 && who == 0));
      chk("stall_mem", stall_mem, dm_req && !(ph == 2 && who == 1));
      if (ph == 1) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_we", mem_we, e_we);
         if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (mem_req && !pm) dq.push_back(mem_we);
      pm = mem_req;
      n_req += int'(mem_req);
      n_done += int'(dm_done);
   endtask
   initial begin
      int lat;
      logic [9:0] pat;
      cycle(); cycle();
      rst = 1'b0;
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
      // single zero-wait fetch
      if_req = 1'b1; if_addr = 16'h0010;
      cycle();
      chk("f_addr", mem_addr, 16'h0010);
      chk("f_we", mem_we, 0);
      mem_ack = 1'b1; mem_rdata = 32'h8C220004;
      cycle();
      chk("f_valid", if_valid, 1);
      chk("f_rdata", if_rdata, 32'h8C220004);
      mem_ack = 1'b0; if_req = 1'b0;
      cycle();
      // simultaneous requests: store first, then fetch
      if_req = 1'b1; if_addr = 16'h0020;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 32'hDEADBEEF;
      cycle();
      chk("s_we", mem_we, 1);
      chk("s_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_stall_if", stall_if, 1);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      cycle();
      chk("s_done", dm_done, 1);
      chk("s_rdata_store", dm_rdata, 0);
      mem_ack = 1'b0; dm_req = 1'b0;
      cycle(); cycle();
      chk("s_fetch_addr", mem_addr, 16'h0020);
      chk("s_stall_if_wait", stall_if, 1);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
      cycle();
      chk("s_fetch_valid", if_valid, 1);
      mem_ack = 1'b0; if_req = 1'b0;
      cycle();
      // starvation guard with continuous stores and fetches, zero-wait memory
      dq.delete();
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 32'h0000_5555;
      for (int i = 0; i < 32; i++) begin
         mem_ack = mem_req;
         cycle();
      end
      pat = 10'b1111011110;
      chk("streak_grants", dq.size() >= 10, 1);
      for (int i = 0; i < 10 && i < dq.size(); i++) chk($sformatf("grant%0d", i), dq[i], pat[9 - i]);
      if_req = 1'b0; dm_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = mem_req;
         cycle();
      end
      mem_ack = 1'b0;
      // successful load, then a load that times out
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040;
      cycle();
      mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
      cycle();
      chk("ld_rdata", dm_rdata, 32'hA5A5A5A5);
      mem_ack = 1'b0; dm_addr = 16'h0044;
      n_req = 0;
      cycle();
      for (int i = 0; i < 300 && !dm_done; i++) cycle();
      chk("to_busy_cycles", n_req, TO);
      chk("to_done", dm_done, 1);
      chk("to_err", err, 1);
      chk("to_rdata", dm_rdata, 0);
      dm_req = 1'b0;
      cycle();
      chk("to_idle", mem_req, 0);
      // reset in the middle of a fetch
      if_req = 1'b1; if_addr = 16'h0030;
      cycle(); cycle(); cycle(); cycle();
      rst = 1'b1; if_req = 1'b0;
      cycle();
      chk("rst_abort_req", mem_req, 0);
      rst = 1'b0;
      cycle();
      mem_ack = 1'b1; mem_rdata = 32'h00000077;
      cycle();
      chk("stray_ack_valid", if_valid, 0);
      chk("stray_ack_rdata", if_rdata, 0);
      mem_ack = 1'b0;
      cycle();
      // wait-state store
      n_req = 0; n_done = 0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 32'h0BADF00D;
      for (int i = 0; i < 6; i++) cycle();
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0; dm_req = 1'b0;
      cycle(); cycle();
      chk("ws_busy_cycles", n_req, 6);
      chk("ws_done_pulses", n_done, 1);
      // randomized traffic with random latency and stray acks
      lat = -1;
      for (int i = 0; i < 600; i++) begin
         if (!if_req || if_valid) begin
            if_req = 1'($urandom_range(0, 1)); if_addr = AW'($urandom);
         end
         if (!dm_req || dm_done) begin
            dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom);
            dm_addr = AW'($urandom); dm_wdata = $urandom;
         end
         mem_rdata = $urandom;
         if (mem_req) begin
            if (lat < 0) lat = $urandom_range(0, 3);
            mem_ack = lat == 0;
            lat--;
         end else begin
            lat = -1;
            mem_ack = $urandom_range(0, 7) == 0;
         end
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
